reg_file_ab: RTL and testbench



---
 rtl/reg_file_ab_if.sv | 29 ++
 rtl/reg_file_ab.sv | 59 +++++
 tb/tb_reg_file_ab.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_ab_if.sv
// reg_file_ab_if: address, data and enable bundle between the multicycle control/datapath and the register file.
// Latency: none; this is wiring only.
// Backpressure: none; the register file accepts every write and latch on the edge it is presented.
// Master drives the addresses, the writeback data and the enables; slave returns the two reads and the A/B operands.
interface reg_file_ab_if #(
    parameter int word_size = 32,
    parameter int addr_size = 5
);
    logic [addr_size-1:0] read_addr0;   // rs
    logic [addr_size-1:0] read_addr1;   // rt
    logic [addr_size-1:0] write_addr;   // destination, from read_mux output_data
    logic [word_size-1:0] write_data;   // ALUOut or MDR
    logic                 write_en;     // RegWrite
    logic                 latch_en;     // capture A/B (ID state)
    logic [word_size-1:0] read_data0;
    logic [word_size-1:0] read_data1;
    logic [word_size-1:0] a_out;
    logic [word_size-1:0] b_out;

    modport master (
        output read_addr0, read_addr1, write_addr, write_data, write_en, latch_en,
        input  read_data0, read_data1, a_out, b_out
    );

    modport slave (
        input  read_addr0, read_addr1, write_addr, write_data, write_en, latch_en,
        output read_data0, read_data1, a_out, b_out
    );
endinterface

// File: rtl/reg_file_ab.sv
// reg_file_ab: 32-entry two-read/one-write register file with the multicycle A/B operand latches.
// Latency: reads are combinational with write-through bypass; writes land and A/B capture on the next rising edge.
// Backpressure: none; every write and latch request is taken on the edge it is presented.
// Ports: clk (rising edge), rst_n (synchronous, active-low), rf (slave side of reg_file_ab_if:
//        read_addr0/1, write_addr, write_data, write_en, latch_en in; read_data0/1, a_out, b_out out).
module reg_file_ab #(
    parameter int word_size = 32,
    parameter int addr_size = 5,
    parameter int num_regs  = 32    // must equal 2**addr_size so every address is in range
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_ab_if.slave rf
);

    // Entry 0 is never written after reset and is masked on read, so it collapses to a constant.
    logic [word_size-1:0] regs [num_regs];

    // Read with register-0 masking and write-through bypass, so a consumer in the same
    // cycle as the writeback (including the A/B capture) sees the new value.
    function automatic logic [word_size-1:0] bypass_read(input logic [addr_size-1:0] addr);
        logic [word_size-1:0] val;
        val = regs[addr];
        if (addr == '0) begin
            val = '0;
        end else if (rf.write_en && (rf.write_addr == addr)) begin
            val = rf.write_data;
        end
        return val;
    endfunction

    always_comb begin
        rf.read_data0 = bypass_read(rf.read_addr0);
        rf.read_data1 = bypass_read(rf.read_addr1);
    end

    // Register storage; reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < num_regs; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.write_en && (rf.write_addr != '0)) begin
            regs[rf.write_addr] <= rf.write_data;
        end
    end

    // A/B capture the bypassed read values, so a write in the decode cycle is seen in EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf.a_out <= '0;
            rf.b_out <= '0;
        end else if (rf.latch_en) begin
            rf.a_out <= rf.read_data0;
            rf.b_out <= rf.read_data1;
        end
    end

endmodule

// File: tb/tb_reg_file_ab.sv
// tb_reg_file_ab: self-checking bench for reg_file_ab using a reference model and an expected-value queue.
// Latency: expected reads are checked within the cycle, expected A/B one edge after the inputs are driven.
// Backpressure: none; the bench drives one request per cycle.
module tb_reg_file_ab;

    localparam int WS = 32;
    localparam int AS = 5;

    logic clk;
    logic rst_n;

    reg_file_ab_if #(.word_size(WS), .addr_size(AS)) rf_bus ();

    reg_file_ab #(.word_size(WS), .addr_size(AS), .num_regs(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { SEL_RD0, SEL_RD1, SEL_A, SEL_B } sel_t;

    typedef struct {
        sel_t        sel;
        logic [31:0] exp;
        string       tag;
    } sb_item_t;

    sb_item_t    sb_q [$];
    logic [31:0] ref_regs [32];
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          num_checks;
    int          num_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input sel_t sel);
        case (sel)
            SEL_RD0: return rf_bus.read_data0;
            SEL_RD1: return rf_bus.read_data1;
            SEL_A:   return rf_bus.a_out;
            default: return rf_bus.b_out;
        endcase
    endfunction

    task automatic sb_push(input sel_t sel, input logic [31:0] exp, input string tag);
        sb_item_t it;
        it.sel = sel;
        it.exp = exp;
        it.tag = tag;
        sb_q.push_back(it);
    endtask

    task automatic sb_drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.tag, observe(it.sel), it.exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (rf_bus.write_en && rf_bus.write_addr == addr) return rf_bus.write_data;
        return ref_regs[addr];
    endfunction

    // One clock: check the combinational reads mid-cycle, then the model state after the edge.
    task automatic cycle();
        logic [31:0] r0, r1, nxt_a, nxt_b;
        #1;
        r0 = model_read(rf_bus.read_addr0);
        r1 = model_read(rf_bus.read_addr1);
        sb_push(SEL_RD0, r0, "rd0");
        sb_push(SEL_RD1, r1, "rd1");
        sb_drain();
        nxt_a = exp_a;
        nxt_b = exp_b;
        if (!rst_n) begin
            nxt_a = 32'h0;
            nxt_b = 32'h0;
        end else if (rf_bus.latch_en) begin
            nxt_a = r0;
            nxt_b = r1;
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        end else if (rf_bus.write_en && rf_bus.write_addr != 5'd0) begin
            ref_regs[rf_bus.write_addr] = rf_bus.write_data;
        end
        exp_a = nxt_a;
        exp_b = nxt_b;
        sb_push(SEL_A, exp_a, "a_out");
        sb_push(SEL_B, exp_b, "b_out");
        #1;
        sb_drain();
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic le);
        rf_bus.write_en   = we;
        rf_bus.write_addr = wa;
        rf_bus.write_data = wd;
        rf_bus.read_addr0 = ra0;
        rf_bus.read_addr1 = ra1;
        rf_bus.latch_en   = le;
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        exp_a = 32'h0;
        exp_b = 32'h0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;

        // Reset held for two edges with a write pending to r5; read only bypassed/zero addresses.
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1);
        cycle();
        cycle();
        rst_n = 1'b1;
        drive(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0);
        sb_push(SEL_RD0, 32'h0, "rst_rd0_r5");
        sb_push(SEL_A, 32'h0, "rst_a");
        sb_push(SEL_B, 32'h0, "rst_b");
        cycle();

        // Write r8, r9, then latch both ports.
        drive(1'b1, 5'd8, 32'hFFFF0000, 5'd1, 5'd2, 1'b0);
        cycle();
        drive(1'b1, 5'd9, 32'h0000FFFF, 5'd1, 5'd2, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b1);
        cycle();
        sb_push(SEL_A, 32'hFFFF0000, "ab_a_r8");
        sb_push(SEL_B, 32'h0000FFFF, "ab_b_r9");
        sb_drain();

        // Register 0 ignores writes and always reads zero, including into A/B.
        drive(1'b1, 5'd0, 32'h88888888, 5'd0, 5'd0, 1'b0);
        sb_push(SEL_RD0, 32'h0, "r0_bypass_rd0");
        cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
        sb_push(SEL_RD1, 32'h0, "r0_rd1");
        cycle();
        sb_push(SEL_A, 32'h0, "r0_a");
        sb_push(SEL_B, 32'h0, "r0_b");
        sb_drain();

        // Bypass: write r3 and latch it in the same cycle.
        drive(1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0, 1'b0);
        cycle();
        drive(1'b1, 5'd3, 32'hFEFEFEFE, 5'd3, 5'd8, 1'b1);
        sb_push(SEL_RD0, 32'hFEFEFEFE, "byp_rd0");
        cycle();
        sb_push(SEL_A, 32'hFEFEFEFE, "byp_a");
        sb_push(SEL_B, 32'hFFFF0000, "byp_b");
        sb_drain();

        // Hold: enables low while everything else toggles.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 5'($urandom_range(0, 31)), 32'h12345678,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
            cycle();
        end
        sb_push(SEL_A, 32'hFEFEFEFE, "hold_a");
        sb_push(SEL_B, 32'hFFFF0000, "hold_b");
        sb_drain();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0);
            cycle();
        end

        // Reset mid-operation with a write to r10 pending.
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b1);
        cycle();
        rst_n = 1'b0;
        drive(1'b1, 5'd10, 32'hCAFEF00D, 5'd8, 5'd9, 1'b1);
        cycle();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b0);
        sb_push(SEL_RD0, 32'h0, "mid_rst_r8");
        sb_push(SEL_RD1, 32'h0, "mid_rst_r9");
        sb_push(SEL_A, 32'h0, "mid_rst_a");
        sb_push(SEL_B, 32'h0, "mid_rst_b");
        cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 1'b0);
        sb_push(SEL_RD0, 32'h0, "mid_rst_r10");
        cycle();

        // Mixed random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
